// File: rtl/aes_v2_seq.sv
// Sequencer that walks a 128-bit AES state through an aes_v2 unit one column word at a time.
// Optional ShiftRows step between SubBytes and MixColumns: define AES_V2_SEQ_SHIFTROWS_EN.
module aes_v2_seq (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_enc,
  input  logic [1:0]   req_ops,
  input  logic [127:0] req_state,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state,
  output logic         cop_valid,
  output logic         cop_sub,
  output logic         cop_enc,
  output logic [31:0]  cop_rs1,
  output logic [31:0]  cop_rs2,
  input  logic         cop_ready,
  input  logic [31:0]  cop_rd
);

`ifdef AES_V2_SEQ_SHIFTROWS_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_SUB = 3'd1, ST_SHR = 3'd2, ST_MIX = 3'd3, ST_DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_SUB = 3'd1, ST_MIX = 3'd3, ST_DONE = 3'd4
  } state_t;
`endif

  state_t         st_r, st_nxt_s;
  logic [1:0]     idx_r, idx_nxt_s;
  logic [127:0]   data_r, data_nxt_s;
  logic           enc_r, enc_nxt_s;
  logic           mix_r, mix_nxt_s;
  logic           hs_s, act_s;

  logic           req_ready_r, req_ready_nxt_s;
  logic           rsp_valid_r, rsp_valid_nxt_s;
  logic [127:0]   rsp_state_r, rsp_state_nxt_s;
  logic           cop_valid_r, cop_valid_nxt_s;
  logic           cop_sub_r, cop_sub_nxt_s;
  logic           cop_enc_r, cop_enc_nxt_s;
  logic [31:0]    cop_rs_r, cop_rs_nxt_s;

`ifdef AES_V2_SEQ_SHIFTROWS_EN
  // Row r rotates left by r columns (forward) or right by r columns (inverse).
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic enc);
    logic [127:0] o;
    logic [1:0]   cc, rr, src;
    o = s;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        cc  = 2'(c);
        rr  = 2'(r);
        src = enc ? (cc + rr) : (cc - rr);
        o[{cc, rr, 3'b000} +: 8] = s[{src, rr, 3'b000} +: 8];
      end
    end
    return o;
  endfunction
`endif

  // Next-state, datapath update and next values of the registered outputs.
  always_comb begin
    st_nxt_s   = st_r;
    idx_nxt_s  = idx_r;
    data_nxt_s = data_r;
    enc_nxt_s  = enc_r;
    mix_nxt_s  = mix_r;
    hs_s       = cop_valid_r && cop_ready;
    case (st_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          data_nxt_s = req_state;
          enc_nxt_s  = req_enc;
          mix_nxt_s  = req_ops[1];
          idx_nxt_s  = 2'd0;
          if (req_ops[0]) begin
            st_nxt_s = ST_SUB;
          end else if (req_ops[1]) begin
            st_nxt_s = ST_MIX;
          end else begin
            st_nxt_s = ST_DONE;
          end
        end else begin
          st_nxt_s = ST_IDLE;
        end
      end
      ST_SUB: begin
        if (hs_s) begin
          data_nxt_s[{idx_r, 5'b00000} +: 32] = cop_rd;
          idx_nxt_s = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
`ifdef AES_V2_SEQ_SHIFTROWS_EN
            st_nxt_s = ST_SHR;
`else
            st_nxt_s = mix_r ? ST_MIX : ST_DONE;
`endif
          end else begin
            st_nxt_s = ST_SUB;
          end
        end else begin
          st_nxt_s = ST_SUB;
        end
      end
`ifdef AES_V2_SEQ_SHIFTROWS_EN
      ST_SHR: begin
        data_nxt_s = shift_rows(data_r, enc_r);
        st_nxt_s   = mix_r ? ST_MIX : ST_DONE;
      end
`endif
      ST_MIX: begin
        if (hs_s) begin
          data_nxt_s[{idx_r, 5'b00000} +: 32] = cop_rd;
          idx_nxt_s = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            st_nxt_s = ST_DONE;
          end else begin
            st_nxt_s = ST_MIX;
          end
        end else begin
          st_nxt_s = ST_MIX;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          st_nxt_s = ST_IDLE;
        end else begin
          st_nxt_s = ST_DONE;
        end
      end
      default: begin
        st_nxt_s = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops cleanly.
    act_s           = (st_nxt_s == ST_SUB) || (st_nxt_s == ST_MIX);
    req_ready_nxt_s = (st_nxt_s == ST_IDLE);
    rsp_valid_nxt_s = (st_nxt_s == ST_DONE);
    cop_valid_nxt_s = act_s;
    cop_sub_nxt_s   = (st_nxt_s == ST_SUB);
    cop_enc_nxt_s   = act_s ? enc_nxt_s : 1'b0;
    cop_rs_nxt_s    = act_s ? data_nxt_s[{idx_nxt_s, 5'b00000} +: 32] : 32'h0000_0000;
    if ((st_nxt_s == ST_DONE) && (st_r != ST_DONE)) begin
      rsp_state_nxt_s = data_nxt_s;
    end else begin
      rsp_state_nxt_s = rsp_state_r;
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      st_r        <= ST_IDLE;
      idx_r       <= 2'd0;
      data_r      <= 128'h0;
      enc_r       <= 1'b0;
      mix_r       <= 1'b0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_state_r <= 128'h0;
      cop_valid_r <= 1'b0;
      cop_sub_r   <= 1'b0;
      cop_enc_r   <= 1'b0;
      cop_rs_r    <= 32'h0000_0000;
    end else begin
      st_r        <= st_nxt_s;
      idx_r       <= idx_nxt_s;
      data_r      <= data_nxt_s;
      enc_r       <= enc_nxt_s;
      mix_r       <= mix_nxt_s;
      req_ready_r <= req_ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_state_r <= rsp_state_nxt_s;
      cop_valid_r <= cop_valid_nxt_s;
      cop_sub_r   <= cop_sub_nxt_s;
      cop_enc_r   <= cop_enc_nxt_s;
      cop_rs_r    <= cop_rs_nxt_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_state = rsp_state_r;
  assign cop_valid = cop_valid_r;
  assign cop_sub   = cop_sub_r;
  assign cop_enc   = cop_enc_r;
  assign cop_rs1   = cop_rs_r;
  assign cop_rs2   = cop_rs_r;

endmodule

// File: tb/tb_aes_v2_seq.sv
// Directed bench for aes_v2_seq with a behavioural aes_v2 responder; honours AES_V2_SEQ_SHIFTROWS_EN.
module tb_aes_v2_seq;

  logic         g_clk = 1'b0;
  logic         g_resetn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_enc = 1'b0;
  logic [1:0]   req_ops = 2'b00;
  logic [127:0] req_state = 128'h0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_state;
  logic         cop_valid, cop_sub, cop_enc;
  logic [31:0]  cop_rs1, cop_rs2;
  logic         cop_ready = 1'b1;
  logic [31:0]  cop_rd;

  int n_pass = 0;
  int n_total = 0;

`ifdef AES_V2_SEQ_SHIFTROWS_EN
  localparam int SHR_EXTRA = 1;
`else
  localparam int SHR_EXTRA = 0;
`endif

  always #5 g_clk = ~g_clk;

  aes_v2_seq dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc(req_enc),
    .req_ops(req_ops), .req_state(req_state),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state),
    .cop_valid(cop_valid), .cop_sub(cop_sub), .cop_enc(cop_enc),
    .cop_rs1(cop_rs1), .cop_rs2(cop_rs2), .cop_ready(cop_ready), .cop_rd(cop_rd)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Behavioural aes_v2: bytewise (inverse) S-box or (inverse) MixColumn of rs1.
  function automatic logic [31:0] cop_model(input logic sub, input logic enc, input logic [31:0] w);
    logic [31:0] o;
    logic [7:0]  m [4];
    logic [7:0]  acc;
    o = 32'h0;
    if (enc) begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    else     begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    for (int r = 0; r < 4; r++) begin
      if (sub) begin
        o[8*r +: 8] = enc ? sbox(w[8*r +: 8]) : inv_sbox(w[8*r +: 8]);
      end else begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(m[j], w[8*((r+j)%4) +: 8]);
        o[8*r +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] shift_model(input logic [127:0] s, input logic enc);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = enc ? ((c + r) % 4) : ((c - r + 4) % 4);
        o[8*(4*c + r) +: 8] = s[8*(4*src + r) +: 8];
      end
    end
    return o;
  endfunction

  always_comb cop_rd = cop_model(cop_sub, cop_enc, cop_rs1);

  // Handshake monitor
  int hs_cnt = 0;
  int sub_cnt = 0;
  int order_err = 0;
  int rs_err = 0;
  logic mix_seen = 1'b0;
  always @(posedge g_clk) begin
    if (g_resetn) begin
      if (req_valid && req_ready) mix_seen <= 1'b0;
      if (cop_valid && cop_rs1 !== cop_rs2) rs_err <= rs_err + 1;
      if (cop_valid && cop_ready) begin
        hs_cnt <= hs_cnt + 1;
        if (cop_sub) begin
          sub_cnt <= sub_cnt + 1;
          if (mix_seen) order_err <= order_err + 1;
        end else begin
          mix_seen <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic issue(input logic enc, input logic [1:0] ops, input logic [127:0] st);
    int w;
    @(negedge g_clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge g_clk);
      w++;
    end
    check("req_ready_idle", {127'h0, req_ready}, 128'h1);
    req_valid = 1'b1; req_enc = enc; req_ops = ops; req_state = st;
    @(posedge g_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 60) begin
      @(posedge g_clk); #1;
      lat++;
    end
  endtask

  // Holds rsp_ready low for two cycles, then completes the response handshake.
  task automatic drain(input logic [127:0] exp);
    for (int i = 0; i < 2; i++) begin
      @(posedge g_clk); #1;
      check("rsp_hold_valid", {127'h0, rsp_valid}, 128'h1);
      check("rsp_hold_req_ready", {127'h0, req_ready}, 128'h0);
      check("rsp_hold_state", rsp_state, exp);
    end
    @(negedge g_clk);
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
    check("rsp_after_hs_valid", {127'h0, rsp_valid}, 128'h0);
    check("rsp_after_hs_req_ready", {127'h0, req_ready}, 128'h1);
    check("rsp_state_kept", rsp_state, exp);
  endtask

  typedef struct {
    logic         enc;
    logic [1:0]   ops;
    logic [127:0] st_in;
    logic [127:0] st_exp;
    int           lat;
  } vec_t;

  localparam logic [127:0] SEQ    = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] SUBSEQ = 128'h76abd7fe_2b670130_c56f6bf2_7b777c63;

  task automatic run_vec(input vec_t v);
    int hs0, sb0, lat, exp_lat, exp_hs;
    hs0 = hs_cnt;
    sb0 = sub_cnt;
    exp_lat = v.lat + (v.ops[0] ? SHR_EXTRA : 0);
    exp_hs  = 4 * (int'(v.ops[0]) + int'(v.ops[1]));
    issue(v.enc, v.ops, v.st_in);
    wait_rsp(0, lat);
    check("rsp_valid_seen", {127'h0, rsp_valid}, 128'h1);
    check("latency", 128'(lat), 128'(exp_lat));
    check("rsp_state", rsp_state, v.st_exp);
    check("cop_handshakes", 128'(hs_cnt - hs0), 128'(exp_hs));
    check("cop_sub_handshakes", 128'(sub_cnt - sb0), 128'(v.ops[0] ? 4 : 0));
    drain(v.st_exp);
  endtask

  vec_t vecs [7];

  initial begin
    int lat;
    logic [65:0] snap_exp;

    vecs[0] = '{1'b1, 2'b11, 128'h0, {16{8'h63}}, 8};
    vecs[1] = '{1'b1, 2'b10, {96'h0, 32'h455313db}, {96'h0, 32'hbca14d8e}, 4};
    vecs[2] = '{1'b0, 2'b10, {96'h0, 32'hbca14d8e}, {96'h0, 32'h455313db}, 4};
    vecs[3] = '{1'b0, 2'b01, {16{8'h63}}, 128'h0, 4};
    vecs[4] = '{1'b1, 2'b01, SEQ, SUBSEQ, 4};
    vecs[5] = '{1'b0, 2'b01, SUBSEQ, SEQ, 4};
    vecs[6] = '{1'b1, 2'b00, 128'h0123456789abcdef_0123456789abcdef,
                128'h0123456789abcdef_0123456789abcdef, 0};
`ifdef AES_V2_SEQ_SHIFTROWS_EN
    vecs[4].st_exp = shift_model(SUBSEQ, 1'b1);
    vecs[5].st_exp = shift_model(SEQ, 1'b0);
`endif

    // Reset values
    repeat (2) @(posedge g_clk);
    #1;
    check("rst_req_ready", {127'h0, req_ready}, 128'h0);
    check("rst_rsp_valid", {127'h0, rsp_valid}, 128'h0);
    check("rst_rsp_state", rsp_state, 128'h0);
    check("rst_cop", {62'h0, cop_valid, cop_sub, cop_enc, cop_rs1, cop_rs2}, 128'h0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    check("rel_req_ready", {127'h0, req_ready}, 128'h1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stall three cycles on MIX word 2
    begin
      int hs0;
      hs0 = hs_cnt;
      issue(1'b1, 2'b10, {96'h0, 32'h455313db});
      @(posedge g_clk); #1;
      @(posedge g_clk); #1;
      cop_ready = 1'b0;
      snap_exp = {1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 31'h0};
      for (int i = 0; i < 3; i++) begin
        @(posedge g_clk); #1;
        check("stall_hold", {62'h0, cop_valid, cop_sub, cop_enc, cop_rs1, cop_rs2},
              {62'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0});
      end
      cop_ready = 1'b1;
      wait_rsp(5, lat);
      check("stall_latency", 128'(lat), 128'(7));
      check("stall_rsp_state", rsp_state, {96'h0, 32'hbca14d8e});
      check("stall_handshakes", 128'(hs_cnt - hs0), 128'(4));
      drain({96'h0, 32'hbca14d8e});
    end

    // Reset during SUB word 1
    issue(1'b1, 2'b11, 128'h0);
    @(posedge g_clk); #1;
    check("mid_pre_valid", {127'h0, cop_valid}, 128'h1);
    g_resetn = 1'b0;
    @(posedge g_clk); #1;
    check("mid_cop_valid", {127'h0, cop_valid}, 128'h0);
    check("mid_rsp_valid", {127'h0, rsp_valid}, 128'h0);
    check("mid_rsp_state", rsp_state, 128'h0);
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    check("mid_req_ready", {127'h0, req_ready}, 128'h1);
    run_vec(vecs[0]);

    check("cop_order", 128'(order_err), 128'h0);
    check("rs1_eq_rs2", 128'(rs_err), 128'h0);
    if (snap_exp[65] !== 1'b1) $display("note: unused snapshot");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
